// File: rtl/vedic_div_pkg.sv
// Shared types and sizing helpers for the vedic_div_16by8 restoring divider.
package vedic_div_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/vedic_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when it fits.
module vedic_div_step
  import vedic_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;

  // Compare in WIDTH+1 bits so the shifted-out remainder bit is not lost.
  always_comb begin
    t    = {rem, msb};
    diff = t - {1'b0, b};
    qbit = (t >= {1'b0, b});
    // rem < b holds on entry, so a taken difference always fits in WIDTH bits.
    rem_next = qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  end

endmodule

// File: rtl/vedic_div_16by8.sv
// Sequential 2W-by-W restoring divider, one quotient bit per clock, with
// start/busy/done handshake and divide-by-zero / quotient-overflow flags.
module vedic_div_16by8
  import vedic_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] c,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   r,
  output logic               dz,
  output logic               ovf
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_next;
  logic             qbit;
  logic [WIDTH-1:0] c_hi;
  logic [WIDTH-1:0] c_lo;
  logic             last;

  assign c_hi = c[2*WIDTH-1:WIDTH];
  assign c_lo = c[WIDTH-1:0];
  assign last = (cnt == CW'(1));

  vedic_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem),
    .msb      (sh[WIDTH-1]),
    .b        (dvs),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: degenerate operands skip straight to FIN.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (b == '0 || c_hi >= b) state_next = FIN;
          else                      state_next = RUN;
        end
      end
      RUN:     if (last) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  // Operand capture, iteration registers and result/flag holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      sh  <= '0;
      dvs <= '0;
      cnt <= '0;
      q   <= '0;
      r   <= '0;
      dz  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dvs <= b;
            dz  <= 1'b0;
            ovf <= 1'b0;
            if (b == '0) begin
              dz <= 1'b1;
              q  <= '1;
              r  <= '0;
            end else if (c_hi >= b) begin
              ovf <= 1'b1;
              q   <= '1;
              r   <= '0;
            end else begin
              rem <= c_hi;
              sh  <= c_lo;
              cnt <= CW'(WIDTH);
            end
          end
        end
        RUN: begin
          // sh doubles as dividend-low shifter and quotient accumulator;
          // q/r are only published on the final iteration.
          rem <= rem_next;
          sh  <= {sh[WIDTH-2:0], qbit};
          cnt <= cnt - 1'b1;
          if (last) begin
            q <= {sh[WIDTH-2:0], qbit};
            r <= rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_div_16by8.sv
// Scoreboard bench for vedic_div_16by8: the driver queues expected results,
// a negedge monitor pops and checks them whenever done is presented.
module tb_vedic_div_16by8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] c = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        dz;
  logic        ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bcnt = 0;
  int op_id = 0;

  typedef struct {
    int         id;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
    int         lat;
    int         e0;
  } exp_t;

  exp_t sb[$];

  vedic_div_16by8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .c     (c),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: count busy cycles and check each done against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 at_cycle=%0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("op%0d_q", e.id), 32'(q), 32'(e.q));
          chk($sformatf("op%0d_r", e.id), 32'(r), 32'(e.r));
          chk($sformatf("op%0d_dz", e.id), 32'(dz), 32'(e.dz));
          chk($sformatf("op%0d_ovf", e.id), 32'(ovf), 32'(e.ovf));
          chk($sformatf("op%0d_latency", e.id), 32'(cyc - e.e0), 32'(e.lat));
          chk($sformatf("op%0d_busy_cycles", e.id), 32'(bcnt), 32'(e.lat + 1));
        end
        bcnt = 0;
      end
    end
  end

  // Wait for idle, present one start pulse, optionally queue its expected result.
  task automatic issue(input logic [15:0] cv, input logic [7:0] bv,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edz, input logic eovf,
                       input int lat, input bit push);
    int   n = 0;
    exp_t e;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
      return;
    end
    op_id++;
    start = 1'b1;
    c = cv;
    b = bv;
    e.id = op_id; e.q = eq; e.r = er; e.dz = edz; e.ovf = eovf;
    e.lat = lat; e.e0 = cyc + 1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    c = ~cv;
    b = ~bv;
  endtask

  initial begin
    logic [7:0]  bv;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] cv;
    int          n;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_q", 32'(q), 0);
    chk("reset_r", 32'(r), 0);
    chk("reset_dz", 32'(dz), 0);
    chk("reset_ovf", 32'(ovf), 0);

    // Directed vectors; dz/ovf finish in the cycle after the accepting edge.
    issue(16'd65025, 8'd255, 8'd255, 8'd0, 1'b0, 1'b0, 8, 1'b1);
    issue(16'd65279, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0, 8, 1'b1);
    issue(16'd15, 8'd3, 8'd5, 8'd0, 1'b0, 1'b0, 8, 1'b1);
    issue(16'd17, 8'd5, 8'd3, 8'd2, 1'b0, 1'b0, 8, 1'b1);
    issue(16'd100, 8'd0, 8'hFF, 8'd0, 1'b1, 1'b0, 0, 1'b1);
    issue(16'h0100, 8'd1, 8'hFF, 8'd0, 1'b0, 1'b1, 0, 1'b1);
    issue(16'h0500, 8'd5, 8'hFF, 8'd0, 1'b0, 1'b1, 0, 1'b1);
    issue(16'h04FF, 8'd5, 8'd255, 8'd4, 1'b0, 1'b0, 8, 1'b1);

    // Start during RUN must be ignored.
    issue(16'd48, 8'd8, 8'd6, 8'd0, 1'b0, 1'b0, 8, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; c = 16'd8; b = 8'd2;
    @(negedge clk);
    start = 1'b0;

    // Asynchronous reset mid-RUN: outputs clear at once, no done follows.
    issue(16'd4, 8'd2, 8'd2, 8'd0, 1'b0, 1'b0, 8, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_done", 32'(done), 0);
    chk("midreset_q", 32'(q), 0);
    chk("midreset_r", 32'(r), 0);
    chk("midreset_dz", 32'(dz), 0);
    chk("midreset_ovf", 32'(ovf), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    issue(16'd4, 8'd2, 8'd2, 8'd0, 1'b0, 1'b0, 8, 1'b1);

    // Sweep of in-range operands.
    for (int i = 0; i < 500; i++) begin
      bv = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(bv) - 1));
      lo = 8'($urandom_range(0, 255));
      cv = {hi, lo};
      issue(cv, bv, 8'(cv / 16'(bv)), 8'(cv % 16'(bv)), 1'b0, 1'b0, 8, 1'b1);
    end

    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
